// File: rtl/sync_reset_pkg.sv
// Shared types and helpers for the synchronous reset sequencer.
package sync_reset_pkg;

   typedef enum logic [1:0] {
      HOLD,
      REL,
      IDLE
   } seq_state_e;

   // Width needed to hold 0..max_val, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic logic asrt(input logic asserted, input bit active_low);
      return asserted ^ active_low;
   endfunction

endpackage

// File: rtl/sync_reset_stretch.sv
// Per-channel reset hold: held by the global sequence until released, or
// held for STRETCH cycles by its own counter after a channel request.
module sync_reset_stretch
   import sync_reset_pkg::*;
#(
   parameter int unsigned STRETCH = 8
) (
   input  logic clk,
   input  logic restart,
   input  logic start,
   input  logic release_en,
   output logic held
);

   localparam int unsigned CW = cnt_width(STRETCH);
   localparam logic [CW-1:0] CNT_LAST = CW'(STRETCH - 1);

   logic          held_q, held_d;
   logic          timed_q, timed_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      held_d  = held_q;
      timed_d = timed_q;
      cnt_d   = cnt_q;
      if (restart) begin
         held_d  = 1'b1;
         timed_d = 1'b0;
         cnt_d   = '0;
      end else if (start) begin
         held_d  = 1'b1;
         timed_d = 1'b1;
         cnt_d   = '0;
      end else if (release_en) begin
         held_d  = 1'b0;
         timed_d = 1'b0;
      end else if (held_q && timed_q) begin
         if (cnt_q == CNT_LAST) begin
            held_d  = 1'b0;
            timed_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      held_q  <= held_d;
      timed_q <= timed_d;
      cnt_q   <= cnt_d;
   end

   // Next-state flag: the parent registers it together with output polarity.
   assign held = held_d;

endmodule

// File: rtl/sync_reset_sequencer.sv
// Multi-channel synchronous reset sequencer: common stretch, then staggered
// release ch0..chN-1, plus global and per-channel soft-reset requests.
module sync_reset_sequencer
   import sync_reset_pkg::*;
#(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned STRETCH        = 8,
   parameter int unsigned GAP            = 2,
   parameter bit          OUT_ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sw_rst_req,
   input  logic [NUM_CH-1:0] ch_rst_req,
   output logic [NUM_CH-1:0] rst_out,
   output logic              seq_busy,
   output logic              seq_done
);

   localparam int unsigned SW = cnt_width(STRETCH);
   localparam int unsigned GW = cnt_width(GAP);
   localparam int unsigned IW = cnt_width(NUM_CH - 1);
   localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH - 1);
   localparam logic [GW-1:0] GAP_LAST     = GW'((GAP == 0) ? 0 : GAP - 1);
   localparam logic [IW-1:0] LAST_CH      = IW'(NUM_CH - 1);
   localparam bit            ALL_AT_ONCE  = (GAP == 0) || (NUM_CH == 1);

   seq_state_e        state_q, state_d;
   logic [SW-1:0]     cnt_q, cnt_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [NUM_CH-1:0] rst_out_q, rst_out_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [NUM_CH-1:0] rel_en, ch_start, held_nxt;
   logic              restart;

   assign restart = rst | sw_rst_req;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      idx_d    = idx_q;
      rel_en   = '0;
      ch_start = '0;
      if (sw_rst_req) begin
         state_d = HOLD;
         cnt_d   = '0;
         gap_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            HOLD: begin
               if (cnt_q == STRETCH_LAST) begin
                  gap_d = '0;
                  if (ALL_AT_ONCE) begin
                     rel_en  = '1;
                     state_d = IDLE;
                  end else begin
                     rel_en[0] = 1'b1;
                     idx_d     = IW'(1);
                     state_d   = REL;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            REL: begin
               if (gap_q == GAP_LAST) begin
                  gap_d = '0;
                  for (int unsigned i = 0; i < NUM_CH; i++) begin
                     if (idx_q == IW'(i)) rel_en[i] = 1'b1;
                  end
                  if (idx_q == LAST_CH) state_d = IDLE;
                  else                  idx_d   = idx_q + 1'b1;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            IDLE:    ch_start = ch_rst_req;
            default: state_d  = HOLD;
         endcase
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         rst_out_d[i] = asrt(held_nxt[i], OUT_ACTIVE_LOW);
      end
      busy_d = (state_d != IDLE);
      done_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HOLD;
         cnt_q     <= '0;
         gap_q     <= '0;
         idx_q     <= '0;
         rst_out_q <= {NUM_CH{asrt(1'b1, OUT_ACTIVE_LOW)}};
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sync_reset_stretch #(
         .STRETCH(STRETCH)
      ) u_stretch (
         .clk       (clk),
         .restart   (restart),
         .start     (ch_start[g]),
         .release_en(rel_en[g]),
         .held      (held_nxt[g])
      );
   end

   assign rst_out  = rst_out_q;
   assign seq_busy = busy_q;
   assign seq_done = done_q;

endmodule

// File: tb/tb_sync_reset_sequencer.sv
// Three parameterisations driven by shared stimulus, compared each cycle
// against a timeline model (edges since restart, per-channel hold timers).
module tb_sync_reset_sequencer;

   localparam int ND = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, sw;
   logic [3:0] req;
   logic [3:0] out_a;
   logic [0:0] out_b;
   logic [2:0] out_c;
   logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;

   sync_reset_sequencer #(
      .NUM_CH(4), .STRETCH(8), .GAP(2), .OUT_ACTIVE_LOW(1'b0)
   ) u_a (
      .clk(clk), .rst(rst), .sw_rst_req(sw), .ch_rst_req(req),
      .rst_out(out_a), .seq_busy(busy_a), .seq_done(done_a)
   );

   sync_reset_sequencer #(
      .NUM_CH(1), .STRETCH(8), .GAP(0), .OUT_ACTIVE_LOW(1'b1)
   ) u_b (
      .clk(clk), .rst(rst), .sw_rst_req(sw), .ch_rst_req(req[0:0]),
      .rst_out(out_b), .seq_busy(busy_b), .seq_done(done_b)
   );

   sync_reset_sequencer #(
      .NUM_CH(3), .STRETCH(1), .GAP(3), .OUT_ACTIVE_LOW(1'b0)
   ) u_c (
      .clk(clk), .rst(rst), .sw_rst_req(sw), .ch_rst_req(req[2:0]),
      .rst_out(out_c), .seq_busy(busy_c), .seq_done(done_c)
   );

   int unsigned n_ch    [ND] = '{4, 1, 3};
   int unsigned stretch [ND] = '{8, 8, 1};
   int unsigned gap     [ND] = '{2, 0, 3};
   bit          alow    [ND] = '{1'b0, 1'b1, 1'b0};
   int unsigned t_m     [ND];
   int unsigned loc_m   [ND][4];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
   endtask

   function automatic int unsigned t_done(input int d);
      return stretch[d] + (n_ch[d] - 1) * gap[d];
   endfunction

   function automatic logic [3:0] exp_out(input int d);
      logic [3:0] v;
      bit asserted;
      v = '0;
      for (int k = 0; k < int'(n_ch[d]); k++) begin
         asserted = (t_m[d] < stretch[d] + k * gap[d]) || (loc_m[d][k] > 0);
         v[k] = asserted ^ alow[d];
      end
      return v;
   endfunction

   task automatic model_step();
      bit idle;
      for (int d = 0; d < ND; d++) begin
         if (rst || sw) begin
            t_m[d] = 0;
            for (int k = 0; k < 4; k++) loc_m[d][k] = 0;
         end else begin
            idle = (t_m[d] >= t_done(d));
            if (t_m[d] < 100000) t_m[d]++;
            for (int k = 0; k < int'(n_ch[d]); k++) begin
               if (loc_m[d][k] > 0) loc_m[d][k]--;
               if (idle && req[k]) loc_m[d][k] = stretch[d];
            end
         end
      end
   endtask

   task automatic check_all();
      check("a_rst_out", 32'(out_a),  32'(exp_out(0)));
      check("a_busy",    32'(busy_a), 32'(t_m[0] < t_done(0)));
      check("a_done",    32'(done_a), 32'(t_m[0] >= t_done(0)));
      check("b_rst_out", 32'(out_b),  32'(exp_out(1)));
      check("b_busy",    32'(busy_b), 32'(t_m[1] < t_done(1)));
      check("b_done",    32'(done_b), 32'(t_m[1] >= t_done(1)));
      check("c_rst_out", 32'(out_c),  32'(exp_out(2)));
      check("c_busy",    32'(busy_c), 32'(t_m[2] < t_done(2)));
      check("c_done",    32'(done_c), 32'(t_m[2] >= t_done(2)));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   logic [3:0] t1_tab [1:16] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE,
                                 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};

   initial begin
      rst = 1'b1;
      sw  = 1'b0;
      req = '0;
      for (int d = 0; d < ND; d++) begin
         t_m[d] = 0;
         for (int k = 0; k < 4; k++) loc_m[d][k] = 0;
      end
      repeat (3) cycle();
      check("reset_a_out",  32'(out_a),  32'h0000_000F);
      check("reset_a_done", 32'(done_a), 32'h0);
      check("reset_b_out",  32'(out_b),  32'h0);

      // Power-on sequence with fixed release edges.
      rst = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         cycle();
         check("t1_a", 32'(out_a), 32'(t1_tab[e]));
         check("t1_b", 32'(out_b), 32'(e >= 8));
         if (e == 13) check("t1_done13", 32'(done_a), 32'h0);
         if (e == 14) check("t1_done14", 32'(done_a), 32'h1);
      end

      // Single-channel request from IDLE.
      req = 4'b0100;
      cycle();
      req = '0;
      check("t3_start", 32'(out_a), 32'h4);
      for (int j = 1; j <= 8; j++) begin
         cycle();
         check("t3_hold", 32'(out_a), (j <= 7) ? 32'h4 : 32'h0);
         check("t3_done", 32'(done_a), 32'h1);
      end

      // Soft reset colliding with a channel request, then a request during HOLD.
      sw  = 1'b1;
      req = 4'b0010;
      cycle();
      sw  = 1'b0;
      req = '0;
      check("t4_sw_wins", 32'(out_a), 32'h0000_000F);
      for (int e = 1; e <= 16; e++) begin
         req = (e == 3) ? 4'b0010 : 4'b0000;
         cycle();
         check("t4_a", 32'(out_a), 32'(t1_tab[e]));
      end
      req = '0;

      // Reset re-asserted mid-HOLD restarts the count.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (3) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         cycle();
         check("t5_b", 32'(out_b), 32'(e >= 8));
      end

      repeat (4000) begin
         rst = ($urandom_range(0, 299) == 0);
         sw  = ($urandom_range(0, 149) == 0);
         req = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
